// File: rtl/multiport_bypass_fifo.sv
// Multi-lane instruction/elastic FIFO: up to WR_PORTS pushes and RD_PORTS pops per cycle,
// with zero-latency bypass of accepted write lanes behind the stored entries.
module multiport_bypass_fifo #(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned DEPTH_LOG2 = 3,
  parameter  int unsigned WR_PORTS   = 2,
  parameter  int unsigned RD_PORTS   = 2,
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2,
  localparam int unsigned WN         = $clog2(WR_PORTS + 1),
  localparam int unsigned RN         = $clog2(RD_PORTS + 1),
  localparam int unsigned CN         = DEPTH_LOG2 + 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [WN-1:0]              wr_num,
  input  logic [WR_PORTS*WIDTH-1:0]  wr_data,
  input  logic [RN-1:0]              rd_num,
  output logic [RD_PORTS*WIDTH-1:0]  rd_data,
  output logic [RN-1:0]              rd_avail,
  output logic [CN-1:0]              count,
  output logic [CN-1:0]              free,
  output logic                       empty,
  output logic                       full,
  output logic                       err_ovf,
  output logic                       err_udf
);

  localparam int unsigned PW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int unsigned AW    = CN + 1;
  localparam int unsigned PMASK = DEPTH - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    r_pnt;
  logic [PW-1:0]    w_pnt;
  logic             wr_ok;
  logic             rd_ok;
  logic [WN-1:0]    wr_acc;
  logic [RN-1:0]    rd_acc;
  logic [AW-1:0]    avail;

  assign free  = CN'(DEPTH) - count;
  assign empty = (count == '0);
  assign full  = (count == CN'(DEPTH));

  // Acceptance uses only the current occupancy; pops never make room for same-cycle pushes.
  always_comb begin
    wr_ok    = (32'(wr_num) <= WR_PORTS) && (32'(wr_num) <= 32'(free));
    wr_acc   = wr_ok ? wr_num : '0;
    avail    = AW'(count) + AW'(wr_acc);
    rd_ok    = (32'(rd_num) <= RD_PORTS) && (32'(rd_num) <= 32'(avail));
    rd_acc   = rd_ok ? rd_num : '0;
    rd_avail = (32'(avail) >= RD_PORTS) ? RN'(RD_PORTS) : RN'(avail);
  end

  // Read lanes walk the stored entries oldest-first, then the accepted write lanes.
  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < RD_PORTS; k++) begin
      if (k < 32'(count)) begin
        rd_data[k*WIDTH +: WIDTH] = mem[PW'((32'(r_pnt) + k) & PMASK)];
      end else begin
        for (int unsigned j = 0; j < WR_PORTS; j++) begin
          if ((j < 32'(wr_acc)) && (k == 32'(count) + j)) begin
            rd_data[k*WIDTH +: WIDTH] = wr_data[j*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int unsigned i = 0; i < WR_PORTS; i++) begin
        if (i < 32'(wr_acc)) begin
          mem[PW'((32'(w_pnt) + i) & PMASK)] <= wr_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pnt   <= '0;
      w_pnt   <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else if (flush) begin
      r_pnt   <= '0;
      w_pnt   <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      w_pnt   <= PW'((32'(w_pnt) + 32'(wr_acc)) & PMASK);
      r_pnt   <= PW'((32'(r_pnt) + 32'(rd_acc)) & PMASK);
      count   <= count + CN'(wr_acc) - CN'(rd_acc);
      err_ovf <= (wr_num != '0) && !wr_ok;
      err_udf <= (rd_num != '0) && !rd_ok;
    end
  end

endmodule

// File: tb/tb_multiport_bypass_fifo.sv
// Bench for multiport_bypass_fifo: directed scenarios plus randomized traffic
// checked against a queue-based model of the entry stream.
module tb_multiport_bypass_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [1:0]  wr_num;
  logic [63:0] wr_data;
  logic [1:0]  rd_num;
  logic [63:0] rd_data;
  logic [1:0]  rd_avail;
  logic [3:0]  count;
  logic [3:0]  free;
  logic        empty;
  logic        full;
  logic        err_ovf;
  logic        err_udf;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mq[$];
  logic        m_ovf;
  logic        m_udf;

  multiport_bypass_fifo #(.WIDTH(32), .DEPTH_LOG2(3), .WR_PORTS(2), .RD_PORTS(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .wr_num(wr_num), .wr_data(wr_data),
    .rd_num(rd_num), .rd_data(rd_data), .rd_avail(rd_avail), .count(count), .free(free),
    .empty(empty), .full(full), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // Model: a write is all-or-nothing against current free space and lane count.
  function automatic int m_wacc();
    int wn;
    wn = int'(wr_num);
    return (wn <= 2 && wn <= 8 - mq.size()) ? wn : 0;
  endfunction

  function automatic int m_racc();
    int rn;
    rn = int'(rd_num);
    return (rn <= 2 && rn <= mq.size() + m_wacc()) ? rn : 0;
  endfunction

  function automatic int m_avail();
    int a;
    a = mq.size() + m_wacc();
    return (a > 2) ? 2 : a;
  endfunction

  function automatic logic [31:0] m_lane(int k);
    if (k < mq.size()) return mq[k];
    if (k < mq.size() + m_wacc()) return wr_data[(k - mq.size())*32 +: 32];
    return 32'h0;
  endfunction

  task automatic drive(input int wn, input logic [31:0] d0, input logic [31:0] d1,
                       input int rn, input logic fl);
    wr_num  = 2'(wn);
    wr_data = {d1, d0};
    rd_num  = 2'(rn);
    flush   = fl;
    #1;
  endtask

  // Advance one clock edge and move the model along with it.
  task automatic step();
    int wa;
    int ra;
    logic [31:0] lanes [2];
    wa = m_wacc();
    ra = m_racc();
    lanes[0] = wr_data[31:0];
    lanes[1] = wr_data[63:32];
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      for (int i = 0; i < wa; i++) mq.push_back(lanes[i]);
      for (int i = 0; i < ra; i++) void'(mq.pop_front());
      m_ovf = (wr_num != 2'd0) && (wa == 0);
      m_udf = (rd_num != 2'd0) && (ra == 0);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 0, 1'b0);
    #10;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", empty, full); end
    n_checks++; if (free !== 4'd8) begin n_fail++; $display("FAIL reset_free: got %0d want 8", free); end
    n_checks++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin n_fail++; $display("FAIL reset_errs: ovf=%b udf=%b want 0 0", err_ovf, err_udf); end
    n_checks++; if (rd_data !== 64'h0 || rd_avail !== 2'd0) begin n_fail++; $display("FAIL reset_rd: data=%h avail=%0d want 0 0", rd_data, rd_avail); end
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bypass();
    drive(2, 32'hA000_0000, 32'hA000_0001, 2, 1'b0);
    n_checks++; if (rd_data !== {32'hA000_0001, 32'hA000_0000}) begin n_fail++; $display("FAIL bypass_data: got %h want a0000001a0000000", rd_data); end
    n_checks++; if (rd_avail !== 2'd2) begin n_fail++; $display("FAIL bypass_avail: got %0d want 2", rd_avail); end
    step();
    n_checks++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL bypass_count: count=%0d empty=%b want 0 1", count, empty); end
    n_checks++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin n_fail++; $display("FAIL bypass_errs: ovf=%b udf=%b want 0 0", err_ovf, err_udf); end
  endtask

  task automatic test_fill_wrap();
    for (int c = 0; c < 4; c++) begin
      drive(2, 32'h100 + 32'(2*c), 32'h101 + 32'(2*c), 0, 1'b0);
      step();
    end
    n_checks++; if (full !== 1'b1 || count !== 4'd8 || free !== 4'd0) begin n_fail++; $display("FAIL fill_full: full=%b count=%0d free=%0d want 1 8 0", full, count, free); end
    drive(1, 32'hDEAD, 0, 0, 1'b0);
    step();
    n_checks++; if (err_ovf !== 1'b1 || count !== 4'd8) begin n_fail++; $display("FAIL fill_ovf: ovf=%b count=%0d want 1 8", err_ovf, count); end
    drive(1, 32'hBEEF, 0, 2, 1'b0);
    n_checks++; if (rd_data !== {32'h101, 32'h100}) begin n_fail++; $display("FAIL fill_head: got %h want 0000010100000100", rd_data); end
    step();
    n_checks++; if (err_ovf !== 1'b1 || count !== 4'd6) begin n_fail++; $display("FAIL full_wr_rd: ovf=%b count=%0d want 1 6", err_ovf, count); end
    for (int c = 1; c < 4; c++) begin
      drive(0, 0, 0, 2, 1'b0);
      n_checks++;
      if (rd_data !== {32'h101 + 32'(2*c), 32'h100 + 32'(2*c)}) begin
        n_fail++; $display("FAIL wrap_pop%0d: got %h want %h", c, rd_data, {32'h101 + 32'(2*c), 32'h100 + 32'(2*c)});
      end
      step();
    end
    n_checks++; if (empty !== 1'b1 || err_ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: empty=%b ovf=%b want 1 0", empty, err_ovf); end
  endtask

  task automatic test_mixed();
    drive(1, 32'hB, 0, 0, 1'b0);
    step();
    drive(2, 32'hC, 32'hD, 2, 1'b0);
    n_checks++; if (rd_data !== {32'hC, 32'hB}) begin n_fail++; $display("FAIL mixed_data: got %h want 0000000c0000000b", rd_data); end
    step();
    drive(0, 0, 0, 0, 1'b0);
    n_checks++; if (count !== 4'd1 || rd_data[31:0] !== 32'hD) begin n_fail++; $display("FAIL mixed_head: count=%0d head=%h want 1 0000000d", count, rd_data[31:0]); end
  endtask

  task automatic test_underflow();
    drive(0, 0, 0, 2, 1'b0);
    step();
    drive(0, 0, 0, 0, 1'b0);
    n_checks++; if (err_udf !== 1'b1) begin n_fail++; $display("FAIL udf_flag: got %b want 1", err_udf); end
    n_checks++; if (count !== 4'd1 || rd_data[31:0] !== 32'hD) begin n_fail++; $display("FAIL udf_keep: count=%0d head=%h want 1 0000000d", count, rd_data[31:0]); end
    drive(0, 0, 0, 1, 1'b0);
    step();
    n_checks++; if (empty !== 1'b1 || err_udf !== 1'b0) begin n_fail++; $display("FAIL udf_drain: empty=%b udf=%b want 1 0", empty, err_udf); end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      drive(2, 32'h200 + 32'(c), 32'h300 + 32'(c), 0, 1'b0);
      step();
    end
    n_checks++; if (count !== 4'd6) begin n_fail++; $display("FAIL flush_pre: count=%0d want 6", count); end
    drive(2, 32'hE, 32'hF, 3, 1'b1);
    n_checks++; if (rd_avail !== 2'd2 || rd_data !== {32'h300, 32'h200}) begin n_fail++; $display("FAIL flush_comb: avail=%0d data=%h want 2 0000030000000200", rd_avail, rd_data); end
    step();
    drive(0, 0, 0, 0, 1'b0);
    n_checks++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_clear: count=%0d empty=%b want 0 1", count, empty); end
    n_checks++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin n_fail++; $display("FAIL flush_errs: ovf=%b udf=%b want 0 0", err_ovf, err_udf); end
  endtask

  task automatic test_reset_mid();
    drive(2, 32'h51, 32'h52, 0, 1'b0); step();
    drive(2, 32'h53, 32'h54, 0, 1'b0); step();
    drive(1, 32'h55, 0, 0, 1'b0);      step();
    drive(0, 0, 0, 0, 1'b0);
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL rstmid_pre: count=%0d want 5", count); end
    #1;
    resetn = 1'b0;
    #1;
    n_checks++; if (count !== 4'd0 || empty !== 1'b1 || free !== 4'd8) begin n_fail++; $display("FAIL rstmid_async: count=%0d empty=%b free=%0d want 0 1 8", count, empty, free); end
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk);
    #3;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      drive(int'($urandom_range(0, 2)), $urandom, $urandom, int'($urandom_range(0, 3)),
            ($urandom_range(0, 15) == 0));
      n_checks++; if (count !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", n, count, mq.size()); end
      n_checks++; if (free !== 4'(8 - mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == 8)) begin
        n_fail++; $display("FAIL rnd_flags @%0d: free=%0d empty=%b full=%b size=%0d", n, free, empty, full, mq.size());
      end
      n_checks++; if (err_ovf !== m_ovf || err_udf !== m_udf) begin n_fail++; $display("FAIL rnd_errs @%0d: ovf=%b udf=%b want %b %b", n, err_ovf, err_udf, m_ovf, m_udf); end
      n_checks++; if (rd_avail !== 2'(m_avail())) begin n_fail++; $display("FAIL rnd_avail @%0d: got %0d want %0d", n, rd_avail, m_avail()); end
      n_checks++; if (rd_data !== {m_lane(1), m_lane(0)}) begin n_fail++; $display("FAIL rnd_data @%0d: got %h want %h", n, rd_data, {m_lane(1), m_lane(0)}); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fill_wrap();
    test_mixed();
    test_underflow();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
